// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage owning the PC, single-outstanding req/ack to imem,
//   registered {pc, instruction, valid} to IF/ID. Latency: ack in cycle N -> output in N+1.
// Backpressure: i_stall holds the output; a word acked during stall is parked in a
//   one-entry skid buffer (HOLD, req dropped) and delivered the cycle after stall drops.
// Ports: i_clk/i_rst (async active-low), i_stall/i_flush/i_redirect/i_redirect_pc from
//   downstream, o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata to memory,
//   o_pc/o_instruction/o_valid to decode, o_fetch_count/o_bubble_count perf counters.
// Optional feature macro: FETCH_PERF_CNT_EN (counters present when defined, else tied to 0).
module instruction_fetch #(
  parameter int                NBITS    = 32,
  parameter logic [NBITS-1:0]  RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_redirect,
  input  logic [NBITS-1:0] i_redirect_pc,
  output logic             o_imem_req,
  output logic [NBITS-1:0] o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [31:0]      i_imem_rdata,
  output logic [NBITS-1:0] o_pc,
  output logic [31:0]      o_instruction,
  output logic             o_valid,
  output logic [31:0]      o_fetch_count,
  output logic [31:0]      o_bubble_count
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [NBITS-1:0] pc, pc_nxt;
  logic [NBITS-1:0] skid_pc, skid_pc_nxt;
  logic [31:0]      skid_instr, skid_instr_nxt;
  logic [NBITS-1:0] out_pc_nxt;
  logic [31:0]      out_instr_nxt;
  logic             valid_nxt;
  logic             ack_ok;
  logic             deliver;
  logic             fetch_inc;
  logic             bubble_inc;

  assign o_imem_addr = pc;

  // An ack only counts while our request is actually out (not in the cycle
  // right after reset, and never in HOLD).
  assign ack_ok = (state == ST_FETCH) && o_imem_req && i_imem_ack;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    out_pc_nxt     = o_pc;
    out_instr_nxt  = o_instruction;
    valid_nxt      = o_valid;
    deliver        = 1'b0;

    if (i_redirect) begin
      // Redirect beats both the skid and any same-cycle ack.
      pc_nxt         = i_redirect_pc;
      state_nxt      = ST_FETCH;
      skid_pc_nxt    = '0;
      skid_instr_nxt = '0;
      if (!i_stall) valid_nxt = 1'b0;
    end else if (state == ST_HOLD) begin
      if (!i_stall) begin
        out_pc_nxt    = skid_pc;
        out_instr_nxt = skid_instr;
        valid_nxt     = 1'b1;
        deliver       = 1'b1;
        state_nxt     = ST_FETCH;
      end
    end else if (ack_ok) begin
      pc_nxt = pc + NBITS'(4);
      if (i_stall) begin
        skid_pc_nxt    = pc;
        skid_instr_nxt = i_imem_rdata;
        state_nxt      = ST_HOLD;
      end else begin
        out_pc_nxt    = pc;
        out_instr_nxt = i_imem_rdata;
        valid_nxt     = 1'b1;
        deliver       = 1'b1;
      end
    end else if (!i_stall) begin
      valid_nxt = 1'b0;
    end

    // Flush only kills the output valid; PC and skid are left alone.
    if (i_flush) valid_nxt = 1'b0;
  end

  // Without stall the output valid is rewritten every edge, so any edge that
  // does not deliver a live word is a bubble.
  assign fetch_inc  = deliver && !i_flush;
  assign bubble_inc = !i_stall && !fetch_inc;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_FETCH;
      pc            <= RESET_PC;
      skid_pc       <= '0;
      skid_instr    <= '0;
      o_imem_req    <= 1'b0;
      o_pc          <= '0;
      o_instruction <= '0;
      o_valid       <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      skid_pc       <= skid_pc_nxt;
      skid_instr    <= skid_instr_nxt;
      o_imem_req    <= (state_nxt == ST_FETCH);
      o_pc          <= out_pc_nxt;
      o_instruction <= out_instr_nxt;
      o_valid       <= valid_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (fetch_inc)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (bubble_inc) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign o_fetch_count  = fetch_cnt;
  assign o_bubble_count = bubble_cnt;
`else
  logic unused_perf;
  assign unused_perf    = fetch_inc ^ bubble_inc;
  assign o_fetch_count  = '0;
  assign o_bubble_count = '0;
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- MIPS instruction-fetch stage.
- Owns the program counter and runs a single-outstanding req/ack handshake with instruction memory.
- Delivers registered {pc, instruction, valid} to the IF/ID boundary, which feeds the decode stage.
- Honours stall, flush and redirect (branch/jump target) from downstream stages; buffers a late-arriving word during a stall so nothing is lost or duplicated.

## Interface
- NBITS, 32, PC and address width
- RESET_PC, 32'h0000_0000, PC value after reset
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_stall  in  1  downstream cannot accept; output register holds
- i_flush  in  1  invalidate output register next edge
- i_redirect  in  1  load PC from i_redirect_pc
- i_redirect_pc  in  NBITS  branch/jump target
- o_imem_req  out  1  fetch request (registered)
- o_imem_addr  out  NBITS  fetch address (= PC)
- i_imem_ack  in  1  memory returns data this cycle; only meaningful while o_imem_req=1
- i_imem_rdata  in  32  instruction word, valid with ack
- o_pc  out  NBITS  PC of o_instruction
- o_instruction  out  32  fetched word
- o_valid  out  1  o_pc/o_instruction hold a live instruction
- o_fetch_count  out  32  delivered-instruction counter (see Configuration)
- o_bubble_count  out  32  bubble-cycle counter (see Configuration)

## Operation
- State machine, two states:
  - FETCH: o_imem_req=1, o_imem_addr=pc.
  - HOLD: o_imem_req=0; skid buffer full.
- Memory samples o_imem_addr only in the ack cycle. The address may change while req=1 without ack.
- FETCH, ack=1, stall=0, redirect=0:
  - output <= {pc, rdata}, o_valid<=1.
  - pc<=pc+4 (modulo 2^NBITS, wraps silently).
  - Stay FETCH.
- FETCH, ack=0, stall=0: o_valid<=0 (bubble); pc unchanged.
- FETCH, ack=1, stall=1, redirect=0:
  - skid <= {pc, rdata}; pc<=pc+4.
  - Go HOLD; output held.
- FETCH, ack=0, stall=1: output held; no state change.
- HOLD, stall=0:
  - output <= skid, o_valid<=1.
  - Go FETCH; req=1 from the next cycle.
- HOLD, stall=1: hold everything.
- Redirect (any state) has priority over increment:
  - pc<=i_redirect_pc; skid discarded; go FETCH.
  - A same-cycle ack is discarded.
  - Output gets o_valid<=0 if stall=0, held if stall=1.
- i_flush:
  - o_valid<=0 regardless of stall; o_pc/o_instruction may keep stale values.
  - Skid buffer and PC are not affected.
- Flush and redirect together: both apply.
- i_redirect_pc is loaded as given; no alignment check.

## Timing
- Reset values (asserted asynchronously):
  - pc=RESET_PC, state=FETCH, o_imem_req=0, o_valid=0, o_pc=0, o_instruction=0 (NOP).
  - Skid cleared; counters=0.
- o_imem_req rises on the first rising edge after i_rst deasserts.
- o_imem_addr=RESET_PC from reset.
- Ack in cycle N → o_valid/o_instruction visible in cycle N+1; new address visible in cycle N+1.
- Zero-wait memory (ack every cycle) → one instruction per cycle, no bubbles.
- Stall released in HOLD in cycle M → buffered word on output in M+1; next ack possible in M+1.
- Reset mid-transaction: outstanding request abandoned; ack during reset ignored.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - o_fetch_count increments on every edge that loads o_valid=1.
  - o_bubble_count increments on every edge that loads o_valid=0 with stall=0.
  - Both wrap at 2^32 and reset to 0.
- FETCH_PERF_CNT_EN undefined:
  - Counters not synthesised; both ports tied to 0.
  - All other behaviour identical.

## Test plan
- Reset release, ack tied 1, rdata=addr → o_pc 0x0,0x4,0x8… consecutively with o_valid=1 from first cycle after first ack; o_instruction=o_pc.
- Ack delayed 3 cycles for addr 0x4 → o_imem_addr stays 0x4, o_valid=0 for 3 cycles, then o_pc=0x4 valid; bubble count +3 (macro on).
- Stall=1 in the ack cycle of 0x8 and held 2 cycles → output holds 0x4, req=0 in HOLD, o_pc=0x8 appears the cycle after stall drops, then 0xC; no duplicate/missing PC.
- Redirect to 0x100 in the same cycle as ack of 0x10 → 0x10 never valid, next o_valid=1 carries o_pc=0x100, then 0x104.
- Flush with stall=1 while o_pc=0x20 valid → o_valid=0 next cycle; PC and skid untouched; fetch resumes at the current pc when stall drops.
- Assert reset while req pending at 0x40 with ack arriving → outputs instantly at reset values; after release fetch restarts at RESET_PC; counters read 0 (macro on) or 0 always (macro off).
